// File: rtl/daynight_fader_pkg.sv
// Shared types for the day/night fader: sequencer phases and force-mode decode.
package daynight_fader_pkg;

  typedef enum logic [1:0] {
    DAY      = 2'd0,
    FADE_IN  = 2'd1,
    NIGHT    = 2'd2,
    FADE_OUT = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    FM_AUTO  = 2'b00,
    FM_DAY   = 2'b01,
    FM_NIGHT = 2'b10
  } fm_t;

  // The unused code 11 behaves as automatic sequencing.
  function automatic fm_t decode_fm(input logic [1:0] raw);
    case (raw)
      2'b01:   return FM_DAY;
      2'b10:   return FM_NIGHT;
      default: return FM_AUTO;
    endcase
  endfunction

endpackage

// File: rtl/daynight_blend_ch.sv
// One colour channel of the cross-fade: stage 1 captures the pixel, its complement
// and both blend weights; stage 2 forms (p*b + q*a) >> ALPHA_W and holds it between valid pixels.
module daynight_blend_ch #(
  parameter int unsigned CH_W    = 4,
  parameter int unsigned ALPHA_W = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              load,
  input  logic [CH_W-1:0]   pix_in,
  input  logic [ALPHA_W:0]  alpha,
  output logic [CH_W-1:0]   pix_out
);

  localparam int unsigned      PROD_W     = CH_W + ALPHA_W + 1;
  localparam logic [ALPHA_W:0] ALPHA_FULL = (ALPHA_W+1)'(2**ALPHA_W);

  logic [CH_W-1:0]   p_q;
  logic [CH_W-1:0]   q_q;
  logic [ALPHA_W:0]  a_q;
  logic [ALPHA_W:0]  b_q;
  logic [PROD_W-1:0] mix;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      p_q <= '0;
      q_q <= '0;
      a_q <= '0;
      b_q <= '0;
    end else begin
      p_q <= pix_in;
      q_q <= ~pix_in;
      a_q <= alpha;
      b_q <= ALPHA_FULL - alpha;
    end
  end

  // The weights sum to 2^ALPHA_W, so the sum never needs the top bit and
  // the end points come out exactly as p and ~p.
  always_comb begin
    mix = PROD_W'(p_q) * PROD_W'(b_q) + PROD_W'(q_q) * PROD_W'(a_q);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pix_out <= '0;
    end else if (load) begin
      pix_out <= CH_W'(mix >> ALPHA_W);
    end
  end

endmodule

// File: rtl/daynight_fader.sv
// Day/night colour controller: phase sequencer with stepped alpha plus a
// per-channel 2-stage cross-fade between each pixel and its complement.
//   state    | meaning
//   DAY      | alpha=0, counting hold ticks before fading to night
//   FADE_IN  | alpha rises by one per step until full
//   NIGHT    | alpha=full, counting hold ticks before fading to day
//   FADE_OUT | alpha falls by one per step until zero
module daynight_fader
  import daynight_fader_pkg::*;
#(
  parameter int unsigned CH_W       = 4,
  parameter int unsigned N_CH       = 3,
  parameter int unsigned TICK_DIV   = 50000000,
  parameter int unsigned HOLD_TICKS = 50,
  parameter int unsigned ALPHA_W    = 4,
  parameter int unsigned STEP_DIV   = 1562500
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 enable,
  input  logic                 restart,
  input  logic [1:0]           force_mode,
  input  logic [N_CH*CH_W-1:0] pix_in,
  input  logic                 pix_in_valid,
  output logic [N_CH*CH_W-1:0] pix_out,
  output logic                 pix_out_valid,
  output logic                 is_night,
  output logic                 fading,
  output logic [ALPHA_W:0]     alpha
);

  localparam int unsigned TICK_W = $clog2(TICK_DIV);
  localparam int unsigned HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam int unsigned STEP_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICK_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLD_TICKS - 1);
  localparam logic [STEP_W-1:0] STEP_LAST  = STEP_W'(STEP_DIV - 1);
  localparam logic [ALPHA_W:0]  ALPHA_FULL = (ALPHA_W+1)'(2**ALPHA_W);
  localparam logic [ALPHA_W:0]  ALPHA_ONE  = (ALPHA_W+1)'(1);
  localparam logic [ALPHA_W:0]  ALPHA_TOP  = ALPHA_FULL - ALPHA_ONE;

  state_t            state, state_n;
  logic [ALPHA_W:0]  alpha_n;
  logic [TICK_W-1:0] tick_cnt, tick_n;
  logic [HOLD_W-1:0] hold_cnt, hold_n;
  logic [STEP_W-1:0] step_cnt, step_n;
  fm_t               fm;
  logic              holding;
  logic              in_fade;
  logic              tick;
  logic              step;
  logic              s1_valid;

  assign fm      = decode_fm(force_mode);
  assign holding = (state == DAY) || (state == NIGHT);
  assign in_fade = (state == FADE_IN) || (state == FADE_OUT);
  assign tick    = enable && holding && (tick_cnt == TICK_LAST);
  assign step    = enable && in_fade && (step_cnt == STEP_LAST);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= DAY;
      alpha    <= '0;
      tick_cnt <= '0;
      hold_cnt <= '0;
      step_cnt <= '0;
      is_night <= 1'b0;
      fading   <= 1'b0;
    end else begin
      state    <= state_n;
      alpha    <= alpha_n;
      tick_cnt <= tick_n;
      hold_cnt <= hold_n;
      step_cnt <= step_n;
      is_night <= (state_n == NIGHT);
      fading   <= (state_n == FADE_IN) || (state_n == FADE_OUT);
    end
  end

  always_comb begin
    state_n = state;
    alpha_n = alpha;
    tick_n  = tick_cnt;
    hold_n  = hold_cnt;
    step_n  = step_cnt;
    if (restart) begin
      state_n = DAY;
      alpha_n = '0;
      tick_n  = '0;
      hold_n  = '0;
      step_n  = '0;
    end else begin
      if (enable && holding) tick_n = tick ? '0 : tick_cnt + TICK_W'(1);
      if (enable && in_fade) step_n = step ? '0 : step_cnt + STEP_W'(1);
      unique case (state)
        DAY: begin
          if (fm == FM_NIGHT) begin
            state_n = FADE_IN;
          end else if (tick && fm == FM_AUTO) begin
            if (hold_cnt == HOLD_LAST) state_n = FADE_IN;
            else                       hold_n  = hold_cnt + HOLD_W'(1);
          end
        end
        FADE_IN: begin
          if (fm == FM_DAY) begin
            state_n = FADE_OUT;
          end else if (step) begin
            if (alpha >= ALPHA_TOP) begin
              alpha_n = ALPHA_FULL;
              state_n = NIGHT;
            end else begin
              alpha_n = alpha + ALPHA_ONE;
            end
          end
        end
        NIGHT: begin
          if (fm == FM_DAY) begin
            state_n = FADE_OUT;
          end else if (tick && fm == FM_AUTO) begin
            if (hold_cnt == HOLD_LAST) state_n = FADE_OUT;
            else                       hold_n  = hold_cnt + HOLD_W'(1);
          end
        end
        FADE_OUT: begin
          if (fm == FM_NIGHT) begin
            state_n = FADE_IN;
          end else if (step) begin
            // A forced reversal can enter FADE_OUT with alpha already at 0.
            if (alpha <= ALPHA_ONE) begin
              alpha_n = '0;
              state_n = DAY;
            end else begin
              alpha_n = alpha - ALPHA_ONE;
            end
          end
        end
        default: state_n = DAY;
      endcase
      if (fm != FM_AUTO || state_n != state) hold_n = '0;
      if (state_n != state) begin
        tick_n = '0;
        step_n = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_valid      <= 1'b0;
      pix_out_valid <= 1'b0;
    end else begin
      s1_valid      <= pix_in_valid;
      pix_out_valid <= s1_valid;
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    daynight_blend_ch #(
      .CH_W    (CH_W),
      .ALPHA_W (ALPHA_W)
    ) u_blend (
      .clk     (clk),
      .rstn    (rstn),
      .load    (s1_valid),
      .pix_in  (pix_in[c*CH_W +: CH_W]),
      .alpha   (alpha),
      .pix_out (pix_out[c*CH_W +: CH_W])
    );
  end

endmodule
